debug_cmd_tx: RTL

Host-side initiator for the debug serial command link. It accepts 8-bit commands on a valid/ready port and serializes each one MSB-first onto debug_clk/debug_cs/debug_di. The far-end command receiver samples debug_di on rising debug_clk while debug_cs is high. A command executes at the receiver on the rising edge after its 8th bit, so this block supplies that extra edge: either the first bit of the next command or a flush bit.

---
 rtl/debug_cmd_tx_if.sv | 27 ++
 rtl/debug_cmd_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/debug_cmd_tx_if.sv
// -----------------------------------------------------------------------------
// debug_cmd_tx_if
// Command-side handshake bundle for the debug serial command initiator.
//   cmd_valid  : command offered by the host
//   cmd_data   : command byte (bit7 must be 1 for a legal command)
//   cmd_ready  : initiator can take a command this cycle
//   cmd_err    : one-cycle pulse, an offered command had bit7=0 and was dropped
//   cmd_done   : one-cycle pulse on the execute edge of an accepted command
// Modports: master (host side) and slave (initiator side).
// -----------------------------------------------------------------------------
interface debug_cmd_tx_if;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       cmd_err;
    logic       cmd_done;

    modport master (
        output cmd_valid, cmd_data,
        input  cmd_ready, cmd_err, cmd_done
    );

    modport slave (
        input  cmd_valid, cmd_data,
        output cmd_ready, cmd_err, cmd_done
    );
endinterface

// File: rtl/debug_cmd_tx.sv
// -----------------------------------------------------------------------------
// debug_cmd_tx
// Host-side initiator for the debug serial command link. Accepts 8-bit commands
// on a valid/ready port and shifts them MSB-first onto debug_clk/cs/di. The far
// end executes a command on the rising edge after its 8th bit, so every command
// is followed either by the first bit of the next command or by a flush bit.
// After reset a zero frame is sent to drain any partial command in the receiver.
//
// Ports:
//   clk, rst_n        : system clock, asynchronous active-low reset
//   cmd               : debug_cmd_tx_if.slave (valid/data/ready/err/done)
//   debug_clk_o       : serial clock, idles low
//   debug_cs_o        : frame select, active high
//   debug_di_o        : serial data to the receiver
//   debug_do_i        : serial data from the receiver
//   resp_data_o/resp_valid_o : response byte and strobe (optional)
//
// Parameter HALF_PERIOD (1..255): clk cycles per debug_clk phase.
// Optional feature macro DEBUG_CMD_TX_RESP_EN: captures debug_do on each
// rising debug_clk of a command's 8 bits and presents it with cmd_done.
// -----------------------------------------------------------------------------
module debug_cmd_tx #(
    parameter int unsigned HALF_PERIOD = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    debug_cmd_tx_if.slave  cmd,
    output logic           debug_clk_o,
    output logic           debug_cs_o,
    output logic           debug_di_o,
    input  logic           debug_do_i
`ifdef DEBUG_CMD_TX_RESP_EN
    ,
    output logic [7:0]     resp_data_o,
    output logic           resp_valid_o
`endif
);
    localparam logic [7:0] HM1 = 8'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {RESYNC, IDLE, SHIFT, FLUSH, TAIL} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sr_q, sr_d;
    logic       clk_q, clk_d;
    logic       cs_q, cs_d;
    logic       di_q, di_d;
    logic       rdy_q, rdy_d;
    logic       err_q, err_d;
    logic       done_q, done_d;
    logic       chain_q, chain_d;

    logic tick, cell_st, cell_end, accept, good;

    assign tick     = (cnt_q == HM1);
    // RESYNC spends its first cycle raising cs before the bit cells start.
    assign cell_st  = (state_q == SHIFT) || (state_q == FLUSH) ||
                      ((state_q == RESYNC) && cs_q);
    assign cell_end = cell_st && tick && clk_q;
    assign accept   = cmd.cmd_valid && rdy_q;
    assign good     = cmd.cmd_data[7];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        clk_d   = clk_q;
        cs_d    = cs_q;
        di_d    = di_q;
        chain_d = chain_q;
        err_d   = 1'b0;

        if (cell_st || (state_q == TAIL)) begin
            cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
        end
        if (cell_st && tick) begin
            clk_d = ~clk_q;
        end

        case (state_q)
            RESYNC: begin
                if (!cs_q) begin
                    cs_d  = 1'b1;
                    cnt_d = 8'd0;
                    bit_d = 3'd0;
                    di_d  = 1'b0;
                end else if (cell_end) begin
                    if (bit_q == 3'd7) state_d = TAIL;
                    else               bit_d = bit_q + 3'd1;
                end
            end
            IDLE: begin
                if (accept) begin
                    if (good) begin
                        sr_d    = cmd.cmd_data;
                        di_d    = cmd.cmd_data[7];
                        bit_d   = 3'd0;
                        cnt_d   = 8'd0;
                        clk_d   = 1'b0;
                        cs_d    = 1'b1;
                        chain_d = 1'b0;
                        state_d = SHIFT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cell_end) begin
                    if (bit_q != 3'd7) begin
                        bit_d = bit_q + 3'd1;
                        di_d  = sr_q[6];
                        sr_d  = {sr_q[6:0], 1'b0};
                    end else if (accept && good) begin
                        // Next command's bit7 doubles as this one's execute edge.
                        sr_d    = cmd.cmd_data;
                        di_d    = cmd.cmd_data[7];
                        bit_d   = 3'd0;
                        chain_d = 1'b1;
                    end else begin
                        err_d   = accept;
                        di_d    = 1'b0;
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (cell_end) begin
                    di_d    = 1'b0;
                    state_d = TAIL;
                end
            end
            TAIL: begin
                di_d = 1'b0;
                if (tick) begin
                    cs_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = RESYNC;
        endcase

        // Ready is registered: predict the final high cycle of bit 0.
        rdy_d  = (state_d == IDLE) ||
                 ((state_d == SHIFT) && (bit_d == 3'd7) && clk_d && (cnt_d == HM1));
        // Execute edge: rising debug_clk of the flush cell or of a chained bit7.
        done_d = clk_d && !clk_q &&
                 ((state_d == FLUSH) || ((state_d == SHIFT) && (bit_d == 3'd0) && chain_d));
    end

`ifdef DEBUG_CMD_TX_RESP_EN
    logic [7:0] rsr_q, rsr_d, rdata_q, rdata_d;
    logic       rvld_q;

    always_comb begin
        rsr_d = rsr_q;
        if ((state_q == SHIFT) && clk_d && !clk_q) begin
            rsr_d = {rsr_q[6:0], debug_do_i};
        end
        // On a chained edge rsr_q still holds the previous command's 8 bits.
        rdata_d = done_d ? rsr_q : rdata_q;
    end
`else
    logic unused_do;
    assign unused_do = debug_do_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESYNC;
            cnt_q   <= 8'd0;
            bit_q   <= 3'd0;
            sr_q    <= 8'd0;
            clk_q   <= 1'b0;
            cs_q    <= 1'b0;
            di_q    <= 1'b0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            chain_q <= 1'b0;
`ifdef DEBUG_CMD_TX_RESP_EN
            rsr_q   <= 8'd0;
            rdata_q <= 8'd0;
            rvld_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            clk_q   <= clk_d;
            cs_q    <= cs_d;
            di_q    <= di_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            done_q  <= done_d;
            chain_q <= chain_d;
`ifdef DEBUG_CMD_TX_RESP_EN
            rsr_q   <= rsr_d;
            rdata_q <= rdata_d;
            rvld_q  <= done_d;
`endif
        end
    end

    assign cmd.cmd_ready = rdy_q;
    assign cmd.cmd_err   = err_q;
    assign cmd.cmd_done  = done_q;
    assign debug_clk_o   = clk_q;
    assign debug_cs_o    = cs_q;
    assign debug_di_o    = di_q;
`ifdef DEBUG_CMD_TX_RESP_EN
    assign resp_data_o   = rdata_q;
    assign resp_valid_o  = rvld_q;
`endif
endmodule
